// File: rtl/seq_det_pkg.sv
// Shared types, defaults and the pattern-matching transition for the serial detector.
package seq_det_pkg;

  localparam int         PAT_W_MAX   = 16;
  localparam logic [3:0] PAT_RST_DEF = 4'b1010;
  localparam logic       OVL_RST_DEF = 1'b0;

  function automatic int st_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Longest pattern prefix that is a suffix of (prefix of length s_eff, then b).
  // Loops are bounded by PAT_W_MAX so the function stays synthesizable.
  function automatic int next_state(input logic [PAT_W_MAX-1:0] pat, input int s,
                                    input logic b, input logic ovl, input int pat_w);
    int         s_eff;
    int         len;
    int         cj;
    int         res;
    logic       found;
    logic       ok;
    logic       cbit;
    logic [3:0] ci;
    logic [3:0] pi;
    res   = 0;
    found = 1'b0;
    s_eff = (s == pat_w && !ovl) ? 0 : s;
    len   = s_eff + 1;
    if (s <= pat_w) begin
      for (int k = PAT_W_MAX; k >= 1; k--) begin
        if (!found && k <= pat_w && k <= len) begin
          ok = 1'b1;
          for (int i = 0; i < PAT_W_MAX; i++) begin
            if (i < k) begin
              cj   = len - k + i;
              ci   = 4'(pat_w - 1 - cj);
              pi   = 4'(pat_w - 1 - i);
              cbit = (cj == s_eff) ? b : pat[ci];
              if (cbit != pat[pi]) ok = 1'b0;
            end
          end
          if (ok) begin
            found = 1'b1;
            res   = k;
          end
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/moore_seq_detector_if.sv
// Configuration, serial input and detect/count outputs of the pattern detector.
interface moore_seq_detector_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             cfg_load;
  logic [PAT_W-1:0] pattern;
  logic             overlap;
  logic             in_valid;
  logic             in;
  logic             out;
  logic [CNT_W-1:0] match_count;

  modport master (
    output cfg_load, pattern, overlap, in_valid, in,
    input  out, match_count
  );

  modport slave (
    input  cfg_load, pattern, overlap, in_valid, in,
    output out, match_count
  );
endinterface

// File: rtl/seq_det_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module seq_det_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector: programmable pattern, overlap mode, valid qualifier,
// saturating match counter. out is decoded from the state register only.
module moore_seq_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF),
  parameter logic             OVL_RST = OVL_RST_DEF
) (
  input logic                 clk,
  input logic                 rst,
  moore_seq_detector_if.slave bus
);

  localparam int              ST_W    = st_width(PAT_W);
  localparam logic [ST_W-1:0] ST_FULL = ST_W'(PAT_W);

  logic [ST_W-1:0]  st;
  logic [ST_W-1:0]  st_d;
  logic [PAT_W-1:0] pat_q;
  logic             ovl_q;
  logic             hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= '0;
      pat_q <= PAT_RST;
      ovl_q <= OVL_RST;
    end else if (bus.cfg_load) begin
      st    <= '0;
      pat_q <= bus.pattern;
      ovl_q <= bus.overlap;
    end else begin
      st    <= st_d;
    end
  end

  // Out-of-range states recover to idle regardless of in_valid.
  always_comb begin
    st_d = st;
    hit  = 1'b0;
    if (st > ST_FULL) begin
      st_d = '0;
    end else if (bus.in_valid) begin
      st_d = ST_W'(next_state(PAT_W_MAX'(pat_q), int'(st), bus.in, ovl_q, PAT_W));
      hit  = (st_d == ST_FULL);
    end
  end

  assign bus.out = (st == ST_FULL);

  seq_det_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .clr   (rst | bus.cfg_load),
    .inc   (hit),
    .count (bus.match_count)
  );

endmodule
